// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU operation and forwarding codes.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int SHAMT_W    = 5;

  // ALU operation codes carried from ID/EX; unlisted codes produce zero.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // Operand source selects; code 3 is reserved and behaves as FWD_ID.
  typedef enum logic [1:0] {
    FWD_ID  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/barrel_shift.sv
// Logarithmic barrel shifters (left logical, right logical, right arithmetic)
// for a 32-bit word with a 5-bit shift amount.
module sll (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_data
);
  // Five conditional stages shifting by 1, 2, 4, 8, 16.
  always_comb begin
    o_data = i_data;
    for (int s = 0; s < 5; s++) begin
      if (i_shamt[s]) o_data = o_data << (1 << s);
    end
  end
endmodule

module srl (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_data
);
  // Five conditional stages, zero fill from the top.
  always_comb begin
    o_data = i_data;
    for (int s = 0; s < 5; s++) begin
      if (i_shamt[s]) o_data = o_data >> (1 << s);
    end
  end
endmodule

module sra (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_data
);
  // Five conditional stages, fill with the original sign bit.
  always_comb begin
    o_data = i_data;
    for (int s = 0; s < 5; s++) begin
      if (i_shamt[s]) o_data = $unsigned($signed(o_data) >>> (1 << s));
    end
  end
endmodule

// File: rtl/ex_alu.sv
// Combinational RV32I integer ALU. Shifts use only b[4:0]; no flags produced.
module ex_alu
  import core_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_sll;
  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_sra;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt = i_b[SHAMT_W-1:0];

  sll u_sll (.i_data(i_a), .i_shamt(w_shamt), .o_data(w_sll));
  srl u_srl (.i_data(i_a), .i_shamt(w_shamt), .o_data(w_srl));
  sra u_sra (.i_data(i_a), .i_shamt(w_shamt), .o_data(w_sra));

  // Result select; compares return 0/1 in bit 0.
  always_comb begin
    o_result = '0;
    case (alu_op_e'(i_op))
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLL:   o_result = w_sll;
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SRL:   o_result = w_srl;
      ALU_SRA:   o_result = w_sra;
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage_reg.sv
// Execute stage: operand forwarding, ALU, and the EX/MEM pipeline register.
// Register control: reset > flush > stall > load, evaluated per rising edge.
// Flush drops valid/rd_wren but keeps data fields; stall holds everything;
// load captures data even for bubbles, with valid gating rd_wren.
module ex_stage_reg
  import core_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_rs1_data,
  input  logic [XLEN-1:0]       i_rs2_data,
  input  logic [XLEN-1:0]       i_imm,
  input  logic [3:0]            i_alu_op,
  input  logic                  i_opa_sel,
  input  logic                  i_opb_sel,
  input  logic [1:0]            i_fwd_a_sel,
  input  logic [1:0]            i_fwd_b_sel,
  input  logic [XLEN-1:0]       i_mem_fwd_data,
  input  logic [XLEN-1:0]       i_wb_fwd_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_rd_wren,
  output logic                  o_valid,
  output logic [XLEN-1:0]       o_alu_data,
  output logic [XLEN-1:0]       o_store_data,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_rd_wren
);

  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_alu_res;

  logic                  r_valid;
  logic [XLEN-1:0]       r_alu_data;
  logic [XLEN-1:0]       r_store_data;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_wren;

  // Forwarding muxes; the reserved code falls back to the ID-stage value.
  always_comb begin
    w_fwd_rs1 = i_rs1_data;
    w_fwd_rs2 = i_rs2_data;
    case (fwd_sel_e'(i_fwd_a_sel))
      FWD_MEM: w_fwd_rs1 = i_mem_fwd_data;
      FWD_WB:  w_fwd_rs1 = i_wb_fwd_data;
      default: w_fwd_rs1 = i_rs1_data;
    endcase
    case (fwd_sel_e'(i_fwd_b_sel))
      FWD_MEM: w_fwd_rs2 = i_mem_fwd_data;
      FWD_WB:  w_fwd_rs2 = i_wb_fwd_data;
      default: w_fwd_rs2 = i_rs2_data;
    endcase
  end

  assign w_opa = i_opa_sel ? i_pc  : w_fwd_rs1;
  assign w_opb = i_opb_sel ? i_imm : w_fwd_rs2;

  ex_alu u_alu (
    .i_a      (w_opa),
    .i_b      (w_opb),
    .i_op     (i_alu_op),
    .o_result (w_alu_res)
  );

  // EX/MEM register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_alu_data   <= '0;
      r_store_data <= '0;
      r_rd_addr    <= '0;
      r_rd_wren    <= 1'b0;
    end else if (i_flush) begin
      r_valid      <= 1'b0;
      r_rd_wren    <= 1'b0;
    end else if (!i_stall) begin
      r_valid      <= i_valid;
      r_alu_data   <= w_alu_res;
      r_store_data <= w_fwd_rs2;
      r_rd_addr    <= i_rd_addr;
      r_rd_wren    <= i_valid & i_rd_wren;
    end
  end

  assign o_valid      = r_valid;
  assign o_alu_data   = r_alu_data;
  assign o_store_data = r_store_data;
  assign o_rd_addr    = r_rd_addr;
  assign o_rd_wren    = r_rd_wren;

endmodule

// File: tb/tb_ex_stage_reg.sv
// Bench for ex_stage_reg: vector table plus hand-written stall/flush/reset
// sequences; expected EX/MEM words go through a queue and are popped after
// each rising edge.
module tb_ex_stage_reg;
  import core_pkg::*;

  localparam int W = 71; // {valid, rd_wren, rd_addr[5], store[32], alu[32]}

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  logic        i_stall, i_flush, i_valid;
  logic [31:0] i_pc, i_rs1_data, i_rs2_data, i_imm, i_mem_fwd_data, i_wb_fwd_data;
  logic [3:0]  i_alu_op;
  logic        i_opa_sel, i_opb_sel;
  logic [1:0]  i_fwd_a_sel, i_fwd_b_sel;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wren;
  logic        o_valid, o_rd_wren;
  logic [31:0] o_alu_data, o_store_data;
  logic [4:0]  o_rd_addr;

  ex_stage_reg dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_imm(i_imm), .i_alu_op(i_alu_op), .i_opa_sel(i_opa_sel), .i_opb_sel(i_opb_sel),
    .i_fwd_a_sel(i_fwd_a_sel), .i_fwd_b_sel(i_fwd_b_sel),
    .i_mem_fwd_data(i_mem_fwd_data), .i_wb_fwd_data(i_wb_fwd_data),
    .i_rd_addr(i_rd_addr), .i_rd_wren(i_rd_wren),
    .o_valid(o_valid), .o_alu_data(o_alu_data), .o_store_data(o_store_data),
    .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] pc, rs1, rs2, imm, mem, wb;
    logic [3:0]  op;
    logic        opa, opb;
    logic [1:0]  fa, fb;
    logic [31:0] e_alu, e_store;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] pc, rs1, rs2, imm, mem, wb,
                              input logic [3:0] op, input logic opa, opb,
                              input logic [1:0] fa, fb,
                              input logic [31:0] e_alu, e_store);
    vec_t v;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.mem = mem; v.wb = wb;
    v.op = op; v.opa = opa; v.opb = opb; v.fa = fa; v.fb = fb;
    v.e_alu = e_alu; v.e_store = e_store;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hold;
  int tests = 0;
  int fails = 0;

  task automatic push_exp(input logic [W-1:0] e);
    exp_q.push_back(e);
    exp_hold = e;
  endtask

  // Advance one edge, then compare outputs against the oldest expectation.
  task automatic step_check(input string name);
    logic [W-1:0] act, e;
    @(posedge i_clk);
    #1;
    act = {o_valid, o_rd_wren, o_rd_addr, o_store_data, o_alu_data};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: no expectation queued, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got v=%b we=%b rd=%0d st=%h alu=%h, want v=%b we=%b rd=%0d st=%h alu=%h",
                 name, act[70], act[69], act[68:64], act[63:32], act[31:0],
                 e[70], e[69], e[68:64], e[63:32], e[31:0]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_vec(input vec_t v, input logic [4:0] rd, input logic valid,
                           input logic wren);
    i_pc = v.pc; i_rs1_data = v.rs1; i_rs2_data = v.rs2; i_imm = v.imm;
    i_mem_fwd_data = v.mem; i_wb_fwd_data = v.wb; i_alu_op = v.op;
    i_opa_sel = v.opa; i_opb_sel = v.opb; i_fwd_a_sel = v.fa; i_fwd_b_sel = v.fb;
    i_rd_addr = rd; i_valid = valid; i_rd_wren = wren;
  endtask

  // Drive a vector as a normal load and queue its registered result.
  task automatic load_vec(input vec_t v, input logic [4:0] rd, input string name);
    drive_vec(v, rd, 1'b1, 1'b1);
    push_exp({1'b1, 1'b1, rd, v.e_store, v.e_alu});
    step_check(name);
  endtask

  vec_t tmp;

  initial begin
    // -------- fill table --------
    //              pc        rs1           rs2           imm           mem   wb   op  a  b  fa fb  alu           store
    vecs[0]  = mk(32'h0, 32'hFFFFFFF8, 32'h1234,     32'h21,       0,    0,   7,  0, 1, 0, 0, 32'hFFFFFFFC, 32'h1234);
    vecs[1]  = mk(32'h0, 32'hFFFFFFF8, 32'h1234,     32'h21,       0,    0,   6,  0, 1, 0, 0, 32'h7FFFFFFC, 32'h1234);
    vecs[2]  = mk(32'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        0,    0,   3,  0, 0, 0, 0, 32'h1,        32'h1);
    vecs[3]  = mk(32'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        0,    0,   4,  0, 0, 0, 0, 32'h0,        32'h1);
    vecs[4]  = mk(32'h0, 32'h0,        32'h1,        32'h0,        0,    0,   1,  0, 0, 0, 0, 32'hFFFFFFFF, 32'h1);
    vecs[5]  = mk(32'h0, 32'h5,        32'h9,        32'h1,        100,  7,   0,  0, 1, 1, 0, 32'd101,      32'h9);
    vecs[6]  = mk(32'h0, 32'h5,        32'h9,        32'h1,        100,  7,   0,  0, 1, 2, 0, 32'd8,        32'h9);
    vecs[7]  = mk(32'h0, 32'h5,        32'h9,        32'h1,        100,  7,   0,  0, 1, 3, 0, 32'd6,        32'h9);
    vecs[8]  = mk(32'h0, 32'h5,        32'h9,        32'h1,        100,  7,   0,  0, 1, 0, 2, 32'd6,        32'd7);
    vecs[9]  = mk(32'h0, 32'h1,        32'h0,        32'h1F,       0,    0,   2,  0, 1, 0, 0, 32'h80000000, 32'h0);
    vecs[10] = mk(32'h0, 32'hF0F0,     32'hFF00,     32'h0,        0,    0,   5,  0, 0, 0, 0, 32'h0FF0,     32'hFF00);
    vecs[11] = mk(32'h0, 32'hF0F0,     32'hFF00,     32'h0,        0,    0,   8,  0, 0, 0, 0, 32'hFFF0,     32'hFF00);
    vecs[12] = mk(32'h0, 32'hF0F0,     32'hFF00,     32'h0,        0,    0,   9,  0, 0, 0, 0, 32'hF000,     32'hFF00);
    vecs[13] = mk(32'h0, 32'hAAAA,     32'h3,        32'h12345000, 0,    0,   10, 0, 1, 0, 0, 32'h12345000, 32'h3);
    vecs[14] = mk(32'h100, 32'h77,     32'h3,        32'h4,        0,    0,   0,  1, 1, 0, 0, 32'h104,      32'h3);
    vecs[15] = mk(32'h0, 32'h5,        32'h6,        32'h0,        0,    0,   15, 0, 0, 0, 0, 32'h0,        32'h6);
    vecs[16] = mk(32'h0, 32'h80,       32'h23,       32'h0,        0,    0,   7,  0, 0, 0, 1, 32'h2,        32'h0);
    // vec16: fwd_b=MEM (mem=0) so shift amount is 0? no: b = mem = 0 -> 0x80. Fixed below.
    vecs[16] = mk(32'h0, 32'h80,       32'h23,       32'h0,        32'h3, 0,  7,  0, 0, 0, 1, 32'h10,       32'h3);

    // -------- reset --------
    i_stall = 0; i_flush = 0;
    drive_vec(vecs[2], 5'd9, 1'b1, 1'b1);
    i_rst_n = 0;
    push_exp('0); step_check("reset_c1");
    push_exp('0); step_check("reset_c2");
    i_rst_n = 1;

    // -------- table --------
    for (int i = 0; i < NV; i++) load_vec(vecs[i], 5'(i + 1), $sformatf("vec%0d", i));

    // -------- random add/sub --------
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom_range(0, 32'hFFFF);
      if (i % 2 == 0) tmp = mk(0, a, b, 0, 0, 0, 0, 0, 0, 0, 0, a + b, b);
      else            tmp = mk(0, a, b, 0, 0, 0, 1, 0, 0, 0, 0, a - b, b);
      load_vec(tmp, 5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
    end

    // -------- stall --------
    tmp = mk(0, 32'h8, 32'h55, 32'h8, 0, 0, 0, 0, 1, 0, 0, 32'h10, 32'h55);
    load_vec(tmp, 5'd3, "stall_load");
    i_stall = 1;
    for (int i = 0; i < 3; i++) begin
      i_rs1_data = $urandom; i_rs2_data = $urandom; i_rd_addr = 5'(i + 20);
      push_exp(exp_hold);
      step_check($sformatf("stall_hold%0d", i));
    end
    i_stall = 0;
    tmp = mk(0, 32'h20, 32'h66, 32'h1, 0, 0, 0, 0, 1, 0, 0, 32'h21, 32'h66);
    load_vec(tmp, 5'd4, "stall_release");

    // -------- flush + stall --------
    i_stall = 1; i_flush = 1;
    i_rs1_data = 32'hDEAD; i_rd_addr = 5'd30;
    push_exp({2'b00, exp_hold[68:0]});
    step_check("flush_stall");
    i_stall = 0; i_flush = 0;

    // bubble load: data fields captured, valid/wren low
    tmp = mk(0, 32'h3, 32'h44, 32'h2, 0, 0, 0, 0, 1, 0, 0, 32'h5, 32'h44);
    drive_vec(tmp, 5'd7, 1'b0, 1'b1);
    push_exp({2'b00, 5'd7, 32'h44, 32'h5});
    step_check("bubble_load");

    // valid load with rd_wren=0
    drive_vec(tmp, 5'd8, 1'b1, 1'b0);
    push_exp({2'b10, 5'd8, 32'h44, 32'h5});
    step_check("valid_nowren");

    // flush alone after a valid load
    load_vec(tmp, 5'd9, "pre_flush");
    i_flush = 1; i_rs1_data = 32'h1;
    push_exp({2'b00, exp_hold[68:0]});
    step_check("flush_only");
    i_flush = 0;

    // -------- reset during stall, then resume --------
    load_vec(tmp, 5'd10, "pre_rst_stall");
    i_stall = 1; i_rst_n = 0;
    push_exp('0); step_check("rst_in_stall");
    i_rst_n = 1; i_stall = 0;
    load_vec(vecs[5], 5'd11, "after_rst");

    // -------- reset during flush --------
    i_flush = 1; i_rst_n = 0;
    push_exp('0); step_check("rst_in_flush");
    i_rst_n = 1; i_flush = 0;
    load_vec(vecs[14], 5'd12, "after_rst2");

    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL queue_drain: %0d leftover, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
